// File: rtl/gpio_seq_pkg.sv
// Shared types and helpers for the GPIO output-pattern sequencer.
// Optional build macro: GPIO_SEQ_REPCNT_EN (pass-repeat counter).
package gpio_seq_pkg;

  localparam int GPIO_SEQ_WIDTH = 12;
  localparam int GPIO_SEQ_ABITS = 3;
  localparam int GPIO_SEQ_HBITS = 16;

  typedef enum logic [1:0] {IDLE, RUN, FIN} gpio_seq_state_e;

  // Default-width step entry; modules with other widths declare a local
  // typedef of the same shape.
  typedef struct packed {
    logic [GPIO_SEQ_WIDTH-1:0] value;
    logic [GPIO_SEQ_HBITS-1:0] hold;
  } gpio_seq_entry;

  // A run length is usable only when it names at least one step and no
  // more steps than the table holds.
  function automatic logic gpio_seq_len_ok(input int unsigned len,
                                           input int unsigned depth);
    return (len != 0) && (len <= depth);
  endfunction

endpackage

// File: rtl/gpio_seq_table.sv
// Step table: depth x (value, hold) register file, synchronous write,
// combinational reads. A read and write of one index in the same cycle
// returns the old entry.
module gpio_seq_table
  import gpio_seq_pkg::*;
#(
  parameter int width = 12,
  parameter int abits = 3,
  parameter int hbits = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_ena,
  input  logic [abits-1:0] i_wr_addr,
  input  logic [width-1:0] i_wr_value,
  input  logic [hbits-1:0] i_wr_hold,
  input  logic [abits-1:0] i_cur_addr,
  output logic [hbits-1:0] o_cur_hold,
  input  logic [abits-1:0] i_nxt_addr,
  output logic [width-1:0] o_nxt_value
);

  localparam int depth = 1 << abits;

  typedef struct packed {
    logic [width-1:0] value;
    logic [hbits-1:0] hold;
  } entry_t;

  entry_t mem_q [depth];

  // Table storage, cleared on reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < depth; i++) mem_q[i] <= '0;
    end else if (i_wr_ena) begin
      mem_q[i_wr_addr] <= '{value: i_wr_value, hold: i_wr_hold};
    end
  end

  assign o_cur_hold  = mem_q[i_cur_addr].hold;
  assign o_nxt_value = mem_q[i_nxt_addr].value;

endmodule

// File: rtl/gpio_seq.sv
// GPIO output-pattern sequencer: plays a programmed step table onto the
// GPIO output-value path, once or looping, abortable.
// Optional build macro: GPIO_SEQ_REPCNT_EN adds i_rep / o_pass.
module gpio_seq
  import gpio_seq_pkg::*;
#(
  parameter int width = 12,
  parameter int abits = 3,
  parameter int hbits = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_ena,
  input  logic [abits-1:0] i_wr_addr,
  input  logic [width-1:0] i_wr_value,
  input  logic [hbits-1:0] i_wr_hold,
  input  logic [abits:0]   i_len,
  input  logic             i_loop,
  input  logic             i_start,
  input  logic             i_stop,
  output logic             o_busy,
  output logic [width-1:0] o_gpio,
  output logic             o_gpio_upd,
  output logic [abits-1:0] o_step,
  output logic             o_done
`ifdef GPIO_SEQ_REPCNT_EN
  ,
  input  logic [7:0]       i_rep,
  output logic [7:0]       o_pass
`endif
);

  localparam int depth = 1 << abits;

  gpio_seq_state_e  state_q, state_d;
  logic [abits-1:0] idx_q, idx_d;
  logic [hbits-1:0] cnt_q, cnt_d;
  logic [abits:0]   len_q, len_d;
  logic [width-1:0] gpio_q, gpio_d;
  logic             upd_q, upd_d;
`ifdef GPIO_SEQ_REPCNT_EN
  logic [7:0]       rem_q, rem_d;
  logic [7:0]       pass_q, pass_d;
`endif

  logic [hbits-1:0] cur_hold;
  logic [width-1:0] nxt_value;
  logic [abits-1:0] nxt_addr;
  logic             last;

  gpio_seq_table #(.width(width), .abits(abits), .hbits(hbits)) u_table (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_wr_ena    (i_wr_ena),
    .i_wr_addr   (i_wr_addr),
    .i_wr_value  (i_wr_value),
    .i_wr_hold   (i_wr_hold),
    .i_cur_addr  (idx_q),
    .o_cur_hold  (cur_hold),
    .i_nxt_addr  (nxt_addr),
    .o_nxt_value (nxt_value)
  );

  // Next step to load: the following index mid-pass, else step 0
  // (both for a fresh start and for a wrap).
  assign last     = ({1'b0, idx_q} == (len_q - 1'b1));
  assign nxt_addr = (state_q == RUN && !last) ? idx_q + 1'b1 : '0;

  // Sequencer state registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      gpio_q  <= '0;
      upd_q   <= 1'b0;
`ifdef GPIO_SEQ_REPCNT_EN
      rem_q   <= '0;
      pass_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      gpio_q  <= gpio_d;
      upd_q   <= upd_d;
`ifdef GPIO_SEQ_REPCNT_EN
      rem_q   <= rem_d;
      pass_q  <= pass_d;
`endif
    end
  end

  // Next-state logic: start, hold counting, advance / wrap / finish, abort.
  always_comb begin
    logic wrap;
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    gpio_d  = gpio_q;
    upd_d   = 1'b0;
    wrap    = 1'b0;
`ifdef GPIO_SEQ_REPCNT_EN
    rem_d   = rem_q;
    pass_d  = pass_q;
`endif
    case (state_q)
      IDLE: begin
        if (!i_stop && i_start && gpio_seq_len_ok(int'(i_len), depth)) begin
          state_d = RUN;
          idx_d   = '0;
          cnt_d   = '0;
          len_d   = i_len;
          gpio_d  = nxt_value;
          upd_d   = 1'b1;
`ifdef GPIO_SEQ_REPCNT_EN
          rem_d   = i_rep;
          pass_d  = '0;
`endif
        end
      end
      RUN: begin
        if (i_stop) begin
          state_d = IDLE;
        end else if (cnt_q != cur_hold) begin
          cnt_d = cnt_q + 1'b1;
        end else if (!last) begin
          idx_d  = nxt_addr;
          cnt_d  = '0;
          gpio_d = nxt_value;
          upd_d  = 1'b1;
        end else begin
          wrap = i_loop;
`ifdef GPIO_SEQ_REPCNT_EN
          pass_d = pass_q + 8'd1;
          if (!i_loop && rem_q != '0) begin
            wrap  = 1'b1;
            rem_d = rem_q - 8'd1;
          end
`endif
          if (wrap) begin
            idx_d  = '0;
            cnt_d  = '0;
            gpio_d = nxt_value;
            upd_d  = 1'b1;
          end else begin
            state_d = FIN;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign o_busy     = (state_q == RUN);
  assign o_done     = (state_q == FIN);
  assign o_gpio     = gpio_q;
  assign o_gpio_upd = upd_q;
  assign o_step     = idx_q;
`ifdef GPIO_SEQ_REPCNT_EN
  assign o_pass     = pass_q;
`endif

endmodule

// File: tb/tb_gpio_seq.sv
// Directed bench for gpio_seq: single pass, loop, abort, boundaries,
// live table writes, async reset (and repeat count when
// GPIO_SEQ_REPCNT_EN is defined).
module tb_gpio_seq;

  logic        clk, rst;
  logic        wr_ena;
  logic [2:0]  wr_addr;
  logic [11:0] wr_value;
  logic [15:0] wr_hold;
  logic [3:0]  len;
  logic        loop, start, stop;
  logic        busy, upd, done;
  logic [11:0] gpio;
  logic [2:0]  step_idx;
`ifdef GPIO_SEQ_REPCNT_EN
  logic [7:0]  rep, pass;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  gpio_seq dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_wr_ena   (wr_ena),
    .i_wr_addr  (wr_addr),
    .i_wr_value (wr_value),
    .i_wr_hold  (wr_hold),
    .i_len      (len),
    .i_loop     (loop),
    .i_start    (start),
    .i_stop     (stop),
    .o_busy     (busy),
    .o_gpio     (gpio),
    .o_gpio_upd (upd),
    .o_step     (step_idx),
    .o_done     (done)
`ifdef GPIO_SEQ_REPCNT_EN
    ,
    .i_rep      (rep),
    .o_pass     (pass)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [11:0] v, input logic [15:0] h);
    wr_ena = 1'b1; wr_addr = a; wr_value = v; wr_hold = h;
    step(1);
    wr_ena = 1'b0;
  endtask

  task automatic go(input logic [3:0] l);
    len = l; start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  // single-pass expected trace, {busy,done,upd,gpio} per cycle after start
  logic [11:0] g1 [8] = '{12'h001, 12'h002, 12'h002, 12'h002, 12'h004, 12'h004, 12'h004, 12'h004};
  logic        u1 [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic        b1 [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic        d1 [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [11:0] pat [6] = '{12'h001, 12'h002, 12'h002, 12'h002, 12'h004, 12'h004};

  initial begin
    rst = 1'b1; wr_ena = 1'b0; wr_addr = '0; wr_value = '0; wr_hold = '0;
    len = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
`ifdef GPIO_SEQ_REPCNT_EN
    rep = '0;
`endif
    step(2);
    chk("reset_out", 32'({busy, done, upd, gpio, step_idx}), 32'd0);
    rst = 1'b0;
    step(1);

    // single pass
    wr(3'd0, 12'h001, 16'd0);
    wr(3'd1, 12'h002, 16'd2);
    wr(3'd2, 12'h004, 16'd1);
    go(4'd3);
    for (int k = 0; k < 8; k++) begin
      chk("single", 32'({busy, done, upd, gpio}), 32'({b1[k], d1[k], u1[k], g1[k]}));
      step(1);
    end

    // loop: period 6, no gap at wrap, never done
    loop = 1'b1;
    go(4'd3);
    for (int k = 0; k < 20; k++) begin
      chk("loop", 32'({done, gpio}), 32'({1'b0, pat[k % 6]}));
      step(1);
    end
    loop = 1'b0;            // now at cycle 20, inside step 1
    step(3);
    chk("loop_end_pre", 32'({busy, done, gpio}), 32'({1'b1, 1'b0, 12'h004}));
    step(1);
    chk("loop_end_done", 32'({busy, done, gpio}), 32'({1'b0, 1'b1, 12'h004}));

    // abort
    wr(3'd0, 12'h0F0, 16'd100);
    wr(3'd1, 12'h00F, 16'd100);
    go(4'd2);
    step(10);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk("abort", 32'({busy, done, upd, gpio}), 32'({1'b0, 1'b0, 1'b0, 12'h0F0}));
    step(1);
    chk("abort_no_done", 32'({busy, done}), 32'd0);
    stop = 1'b1;
    go(4'd2);
    stop = 1'b0;
    chk("start_stop", 32'({busy, upd, gpio}), 32'({1'b0, 1'b0, 12'h0F0}));

    // bad lengths
    go(4'd0);
    chk("len0", 32'({busy, upd}), 32'd0);
    go(4'd9);
    chk("len9", 32'({busy, upd}), 32'd0);

    // full depth, all hold 0
    for (int i = 0; i < 8; i++) wr(3'(i), 12'(1 << i), 16'd0);
    go(4'd8);
    for (int i = 0; i < 8; i++) begin
      chk("full_depth", 32'({step_idx, upd, gpio}), 32'({3'(i), 1'b1, 12'(1 << i)}));
      step(1);
    end
    chk("full_done", 32'({busy, done}), 32'({1'b0, 1'b1}));

    // max hold: step lasts 65536 cycles
    wr(3'd0, 12'h555, 16'hFFFF);
    go(4'd1);
    chk("maxhold_k0", 32'({busy, gpio}), 32'({1'b1, 12'h555}));
    step(65535);
    chk("maxhold_last", 32'({busy, done}), 32'({1'b1, 1'b0}));
    step(1);
    chk("maxhold_done", 32'({busy, done}), 32'({1'b0, 1'b1}));
    step(1);

    // live write of step 2 during step 0
    wr(3'd0, 12'h001, 16'd2);
    wr(3'd1, 12'h002, 16'd2);
    wr(3'd2, 12'h004, 16'd1);
    go(4'd3);
    wr(3'd2, 12'hABC, 16'd1);
    step(5);
    chk("live_wr", 32'({upd, gpio}), 32'({1'b1, 12'hABC}));
    step(2);
    chk("live_done", 32'(done), 32'd1);
    step(1);

    // write and load of step 2 in the same cycle: old data
    go(4'd3);
    step(5);
    wr_ena = 1'b1; wr_addr = 3'd2; wr_value = 12'h123; wr_hold = 16'd1;
    step(1);
    wr_ena = 1'b0;
    chk("war", 32'({upd, gpio}), 32'({1'b1, 12'hABC}));
    step(2);
    chk("war_done", 32'(done), 32'd1);
    step(1);

    // async reset mid-run
    go(4'd3);
    step(1);
    #2 rst = 1'b1;
    #1 chk("async_rst", 32'({busy, done, upd, gpio, step_idx}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1);
    go(4'd1);
    chk("table_cleared", 32'({busy, upd, gpio}), 32'({1'b1, 1'b1, 12'h000}));
    step(2);

`ifdef GPIO_SEQ_REPCNT_EN
    wr(3'd0, 12'h001, 16'd0);
    wr(3'd1, 12'h002, 16'd0);
    wr(3'd2, 12'h004, 16'd0);
    rep = 8'd2;
    go(4'd3);
    step(8);
    chk("rep_last", 32'({busy, done, gpio}), 32'({1'b1, 1'b0, 12'h004}));
    step(1);
    chk("rep_done", 32'({busy, done, pass}), 32'({1'b0, 1'b1, 8'd3}));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
